xgmii_decoder: RTL and testbench
================================

Name: xgmii_decoder

Overview:
Receive-side 64b/66b decoder per IEEE 802.3 Clause 49, the mirror of the transmit encoder. Accepts descrambled 32-bit half-blocks plus a 2-bit sync header from the descrambler and reconstructs the 32-bit XGMII RXD/RXC stream toward the MAC. Two input words (lower, then upper) form one 64-bit block. Each block is decoded once and emitted as two XGMII words on consecutive cycles.

Parameters:
DATA_WIDTH, 32, input and XGMII data width; only 32 supported.
HDR_WIDTH, 2, sync header width.
CTRL_WIDTH, DATA_WIDTH/8, XGMII control width.

Ports:
i_clk  in  1  core clock; all logic on rising edge.
i_reset_n  in  1  reset, asynchronous assert, active-low.
i_rx_data  in  32  descrambled half-block; byte 0 of the lower word is the block type field.
i_rx_sync_hdr  in  2  sync header; sampled only with the lower word.
i_rx_data_valid  in  1  word qualifier.
i_rx_block_lock  in  1  block lock from the frame synchroniser.
o_xgmii_rxd  out  32  XGMII data, lane 0 in [7:0].
o_xgmii_rxc  out  4  XGMII control, bit n is lane n.
o_xgmii_valid  out  1  RXD/RXC qualifier.
o_rx_decode_err  out  1  one-cycle pulse per errored block.

Behaviour:
- Reset values: rxd=32'h07070707, rxc=4'hF, valid=0, decode_err=0. Word-phase toggle=0 (lower word expected) and all internal registers cleared.
- Phase toggle flips on each accepted word (valid=1). While i_rx_block_lock=0 it is forced to 0, and input words are discarded.
- Lower word: register data and sync header. No output is produced.
- Upper word accepted at cycle N: form block B[63:0]={upper,lower}, type T=B[7:0], decode the block, and register both output halves.
  - Cycle N+1: lanes 0-3 out, valid=1.
  - Cycle N+2: lanes 4-7 out, valid=1.
  - Back-to-back blocks sustain full rate. The next lower half appears at N+3.
- Header 2'b01 (data block): rxd=B, rxc=0 for both halves.
- Header 2'b10 (control block), decoded by T. "I" means 8'h07 with rxc=1; "D" means data with rxc=0.
  - 8'h1E: all 8 lanes I. B[63:8] must be 0, otherwise error.
  - 8'h78: lane0=FB (ctrl), lanes1-7 = B bytes 1-7 (D).
  - 8'h33: lanes0-3 I, lane4=FB (ctrl), lanes5-7 = B bytes 5-7.
  - Terminate types 87/99/AA/B4/CC/D2/E1/FF (terminate lane n=0..7):
    - lanes 0..n-1 = B bytes 1..n (D).
    - lane n = FD (ctrl).
    - lanes above n = I.
    - Trailing control bits are ignored.
- Error, raised for any of: header 2'b00/2'b11, any other T, or a malformed 1E block.
  - Both halves = 32'hFEFEFEFE, rxc=4'hF.
  - o_rx_decode_err=1 in cycle N+1 only.
- Lock loss: lock falling mid-block discards the held lower word.
  - An already-decoded block still completes its two output cycles.
  - After that, valid=0 unless LOCAL_FAULT_EN is defined.
- Gaps: valid=0 between lower and upper words is legal, and the held lower word is retained. Output valid is low except during the two emission cycles.
- Reset asserted mid-operation returns all outputs to reset values immediately.

Optional Feature:
Macro XGMII_DECODER_LOCAL_FAULT_EN.
- Defined: while i_rx_block_lock=0, after any in-flight block drains, emit a local fault ordered set every cycle with valid=1: rxd=32'h0100009C, rxc=4'b0001. On lock rise, resume normal decode at the next lower word.
- Undefined: while unlocked, valid=0 and rxd/rxc hold 07070707/F.

Test Plan:
1. Idle block: hdr=10, words 0000001E then 00000000 -> N+1 and N+2 each show 07070707/F, err=0.
2. Start lane 0 + data: hdr=10 with 44332278/77665544 (lower/upper), then hdr=01 with DDCCBBAA/11FFEEDD.
   - First block -> 443322FB rxc=0001, then 77665544 rxc=0.
   - Second block -> DDCCBBAA, then 11FFEEDD, both rxc=0.
   - Continuous valid with no gaps.
3. Terminate lane 5: hdr=10, words 332211D2 then 00665544 -> 44332211 rxc=0, then 0707FD55 rxc=1110.
4. Start lane 4: hdr=10, words 00000033 then 33221100 -> 07070707/F, then 332211FB rxc=0001.
5. Errors: header 11 block, and hdr=10 with T=8'h5A -> both halves FEFEFEFE/F, err pulses exactly once per block.
6. Lock/reset:
   - Drop lock after a lower word, raise it again, send a full idle block -> only that block is output.
   - With LOCAL_FAULT_EN defined, the unlocked interval shows 0100009C/0001.
   - Reset asserted mid-block -> outputs 07070707/F, valid=0 immediately.

Source files
------------

// File: rtl/xgmii_decoder.sv
// Receive 64b/66b block decoder: rebuilds the 32-bit XGMII RXD/RXC stream from descrambled half-blocks.
// Latency: a block's lanes 0-3 appear one cycle after its upper word is accepted, and lanes 4-7 one cycle later.
// Backpressure: none; full rate is sustained. Optional macro XGMII_DECODER_LOCAL_FAULT_EN sends local fault while unlocked.
module xgmii_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr,
    input  logic                  i_rx_data_valid,
    input  logic                  i_rx_block_lock,
    output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
    output logic                  o_xgmii_valid,
    output logic                  o_rx_decode_err
);

    localparam logic [31:0] IDLE_DAT = 32'h07070707;
    localparam logic [3:0]  IDLE_CTL = 4'hF;
    localparam logic [31:0] ERR_DAT  = 32'hFEFEFEFE;
`ifdef XGMII_DECODER_LOCAL_FAULT_EN
    localparam logic [31:0] LF_DAT   = 32'h0100009C;
    localparam logic [3:0]  LF_CTL   = 4'b0001;
`endif

    // 0 = next accepted word is the lower half of a block.
    logic        phase;
    logic [31:0] lower_dat;
    logic [1:0]  lower_hdr;

    // Decoded upper half waiting for its output cycle.
    logic        hi_vld;
    logic [31:0] hi_dat;
    logic [3:0]  hi_ctl;

    logic        lower_acc;
    logic        upper_acc;

    logic [63:0] blk;
    logic [63:0] blk_shr;
    logic [63:0] dec_dat;
    logic [7:0]  dec_ctl;
    logic        dec_err;
    logic        term_hit;
    logic [2:0]  term_n;

    assign lower_acc = i_rx_block_lock && i_rx_data_valid && !phase;
    assign upper_acc = i_rx_block_lock && i_rx_data_valid && phase;

    // Map terminate block types onto the lane that carries /T/.
    always_comb begin
        term_hit = 1'b1;
        term_n   = 3'd0;
        case (blk[7:0])
            8'h87:   term_n = 3'd0;
            8'h99:   term_n = 3'd1;
            8'hAA:   term_n = 3'd2;
            8'hB4:   term_n = 3'd3;
            8'hCC:   term_n = 3'd4;
            8'hD2:   term_n = 3'd5;
            8'hE1:   term_n = 3'd6;
            8'hFF:   term_n = 3'd7;
            default: term_hit = 1'b0;
        endcase
    end

    // Decode the assembled block into eight XGMII lanes; errors override everything.
    always_comb begin
        blk     = {i_rx_data, lower_dat};
        blk_shr = blk >> 8;
        dec_dat = '0;
        dec_ctl = '0;
        dec_err = 1'b0;
        if (lower_hdr == 2'b01) begin
            dec_dat = blk;
        end else if (lower_hdr == 2'b10) begin
            case (blk[7:0])
                8'h1E: begin
                    dec_dat = {IDLE_DAT, IDLE_DAT};
                    dec_ctl = 8'hFF;
                    if (blk[63:8] != 56'd0) dec_err = 1'b1;
                end
                8'h78: begin
                    dec_dat = {blk[63:8], 8'hFB};
                    dec_ctl = 8'h01;
                end
                8'h33: begin
                    dec_dat = {blk[63:40], 8'hFB, IDLE_DAT};
                    dec_ctl = 8'h1F;
                end
                default: begin
                    if (term_hit) begin
                        // Lanes below /T/ carry the data bytes that follow the type field.
                        for (int i = 0; i < 8; i++) begin
                            if (i < int'(term_n)) begin
                                dec_dat[8*i +: 8] = blk_shr[8*i +: 8];
                            end else if (i == int'(term_n)) begin
                                dec_dat[8*i +: 8] = 8'hFD;
                                dec_ctl[i]        = 1'b1;
                            end else begin
                                dec_dat[8*i +: 8] = 8'h07;
                                dec_ctl[i]        = 1'b1;
                            end
                        end
                    end else begin
                        dec_err = 1'b1;
                    end
                end
            endcase
        end else begin
            dec_err = 1'b1;
        end
        if (dec_err) begin
            dec_dat = {ERR_DAT, ERR_DAT};
            dec_ctl = 8'hFF;
        end
    end

    // Word phase tracking and lower-half capture; losing lock realigns to the lower word.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase     <= 1'b0;
            lower_dat <= '0;
            lower_hdr <= '0;
        end else begin
            if (!i_rx_block_lock) begin
                phase <= 1'b0;
            end else if (i_rx_data_valid) begin
                phase <= ~phase;
            end
            if (lower_acc) begin
                lower_dat <= i_rx_data;
                lower_hdr <= i_rx_sync_hdr;
            end
        end
    end

    // Output sequencing: lower lanes on the decode cycle, upper lanes next, otherwise idle (or local fault).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_xgmii_rxd     <= IDLE_DAT;
            o_xgmii_rxc     <= IDLE_CTL;
            o_xgmii_valid   <= 1'b0;
            o_rx_decode_err <= 1'b0;
            hi_vld          <= 1'b0;
            hi_dat          <= '0;
            hi_ctl          <= '0;
        end else if (upper_acc) begin
            o_xgmii_rxd     <= dec_dat[31:0];
            o_xgmii_rxc     <= dec_ctl[3:0];
            o_xgmii_valid   <= 1'b1;
            o_rx_decode_err <= dec_err;
            hi_vld          <= 1'b1;
            hi_dat          <= dec_dat[63:32];
            hi_ctl          <= dec_ctl[7:4];
        end else if (hi_vld) begin
            // An in-flight block always drains, even if lock has just dropped.
            o_xgmii_rxd     <= hi_dat;
            o_xgmii_rxc     <= hi_ctl;
            o_xgmii_valid   <= 1'b1;
            o_rx_decode_err <= 1'b0;
            hi_vld          <= 1'b0;
        end else begin
            o_rx_decode_err <= 1'b0;
`ifdef XGMII_DECODER_LOCAL_FAULT_EN
            if (!i_rx_block_lock) begin
                o_xgmii_rxd   <= LF_DAT;
                o_xgmii_rxc   <= LF_CTL;
                o_xgmii_valid <= 1'b1;
            end else begin
                o_xgmii_rxd   <= IDLE_DAT;
                o_xgmii_rxc   <= IDLE_CTL;
                o_xgmii_valid <= 1'b0;
            end
`else
            o_xgmii_rxd   <= IDLE_DAT;
            o_xgmii_rxc   <= IDLE_CTL;
            o_xgmii_valid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_xgmii_decoder.sv
// Directed bench for the XGMII receive decoder.
// Each output cycle is compared against hand-decoded lane values.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_xgmii_decoder;

    logic        i_clk;
    logic        i_reset_n;
    logic [31:0] i_rx_data;
    logic [1:0]  i_rx_sync_hdr;
    logic        i_rx_data_valid;
    logic        i_rx_block_lock;
    logic [31:0] o_xgmii_rxd;
    logic [3:0]  o_xgmii_rxc;
    logic        o_xgmii_valid;
    logic        o_rx_decode_err;

    int n_cmp;
    int n_bad;

    // Expected output while the decoder is unlocked and idle.
`ifdef XGMII_DECODER_LOCAL_FAULT_EN
    localparam logic [31:0] UL_DAT = 32'h0100009C;
    localparam logic [3:0]  UL_CTL = 4'b0001;
    localparam logic        UL_VLD = 1'b1;
`else
    localparam logic [31:0] UL_DAT = 32'h07070707;
    localparam logic [3:0]  UL_CTL = 4'hF;
    localparam logic        UL_VLD = 1'b0;
`endif

    xgmii_decoder dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_rx_data       (i_rx_data),
        .i_rx_sync_hdr   (i_rx_sync_hdr),
        .i_rx_data_valid (i_rx_data_valid),
        .i_rx_block_lock (i_rx_block_lock),
        .o_xgmii_rxd     (o_xgmii_rxd),
        .o_xgmii_rxc     (o_xgmii_rxc),
        .o_xgmii_valid   (o_xgmii_valid),
        .o_rx_decode_err (o_rx_decode_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [31:0] rxd, input logic [3:0] rxc,
                           input logic vld, input logic err);
        chk({tag, ".rxd"}, o_xgmii_rxd, rxd);
        chk({tag, ".rxc"}, {28'd0, o_xgmii_rxc}, {28'd0, rxc});
        chk({tag, ".vld"}, {31'd0, o_xgmii_valid}, {31'd0, vld});
        chk({tag, ".err"}, {31'd0, o_rx_decode_err}, {31'd0, err});
    endtask

    // Present one input word for one cycle, then settle past the edge.
    task automatic drive(input logic [31:0] dat, input logic [1:0] hdr, input logic vld);
        i_rx_data       = dat;
        i_rx_sync_hdr   = hdr;
        i_rx_data_valid = vld;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        i_reset_n       = 1'b0;
        i_rx_data       = '0;
        i_rx_sync_hdr   = '0;
        i_rx_data_valid = 1'b0;
        i_rx_block_lock = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        exp_out("reset", 32'h07070707, 4'hF, 1'b0, 1'b0);
        i_reset_n       = 1'b1;
        i_rx_block_lock = 1'b1;
        drive(32'h0, 2'b00, 1'b0);

        // Idle block
        drive(32'h0000001E, 2'b10, 1'b1);
        exp_out("idle.gap", 32'h07070707, 4'hF, 1'b0, 1'b0);
        drive(32'h00000000, 2'b00, 1'b1);
        exp_out("idle.h0", 32'h07070707, 4'hF, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("idle.h1", 32'h07070707, 4'hF, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("idle.after", 32'h07070707, 4'hF, 1'b0, 1'b0);

        // Start lane 0 followed back-to-back by a data block
        drive(32'h44332278, 2'b10, 1'b1);
        drive(32'h77665544, 2'b00, 1'b1);
        exp_out("s0.h0", 32'h443322FB, 4'b0001, 1'b1, 1'b0);
        drive(32'hDDCCBBAA, 2'b01, 1'b1);
        exp_out("s0.h1", 32'h77665544, 4'b0000, 1'b1, 1'b0);
        drive(32'h11FFEEDD, 2'b00, 1'b1);
        exp_out("data.h0", 32'hDDCCBBAA, 4'b0000, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("data.h1", 32'h11FFEEDD, 4'b0000, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("data.after", 32'h07070707, 4'hF, 1'b0, 1'b0);

        // Terminate lane 5, with an idle gap between the halves
        drive(32'h332211D2, 2'b10, 1'b1);
        drive(32'hDEADBEEF, 2'b11, 1'b0);
        exp_out("t5.gap", 32'h07070707, 4'hF, 1'b0, 1'b0);
        drive(32'h00665544, 2'b00, 1'b1);
        exp_out("t5.h0", 32'h44332211, 4'b0000, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("t5.h1", 32'h0707FD55, 4'b1110, 1'b1, 1'b0);

        // Terminate lane 0 and lane 7
        drive(32'h00000087, 2'b10, 1'b1);
        drive(32'h00000000, 2'b00, 1'b1);
        exp_out("t0.h0", 32'h070707FD, 4'hF, 1'b1, 1'b0);
        drive(32'h776655FF, 2'b10, 1'b1);
        exp_out("t0.h1", 32'h07070707, 4'hF, 1'b1, 1'b0);
        drive(32'hBBAA9988, 2'b00, 1'b1);
        exp_out("t7.h0", 32'h88776655, 4'b0000, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("t7.h1", 32'hFDBBAA99, 4'b1000, 1'b1, 1'b0);

        // Start lane 4
        drive(32'h00000033, 2'b10, 1'b1);
        drive(32'h33221100, 2'b00, 1'b1);
        exp_out("s4.h0", 32'h07070707, 4'hF, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("s4.h1", 32'h332211FB, 4'b0001, 1'b1, 1'b0);

        // Errors: bad header, unknown type, malformed idle
        drive(32'h0000001E, 2'b11, 1'b1);
        drive(32'h00000000, 2'b00, 1'b1);
        exp_out("eh.h0", 32'hFEFEFEFE, 4'hF, 1'b1, 1'b1);
        drive(32'h0000005A, 2'b10, 1'b1);
        exp_out("eh.h1", 32'hFEFEFEFE, 4'hF, 1'b1, 1'b0);
        drive(32'h12345678, 2'b00, 1'b1);
        exp_out("et.h0", 32'hFEFEFEFE, 4'hF, 1'b1, 1'b1);
        drive(32'h0000011E, 2'b10, 1'b1);
        exp_out("et.h1", 32'hFEFEFEFE, 4'hF, 1'b1, 1'b0);
        drive(32'h00000000, 2'b00, 1'b1);
        exp_out("e1e.h0", 32'hFEFEFEFE, 4'hF, 1'b1, 1'b1);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("e1e.h1", 32'hFEFEFEFE, 4'hF, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("err.after", 32'h07070707, 4'hF, 1'b0, 1'b0);

        // Lock drop after a lower word discards it
        drive(32'h44332278, 2'b10, 1'b1);
        i_rx_block_lock = 1'b0;
        drive(32'h77665544, 2'b00, 1'b1);
        exp_out("unlock", UL_DAT, UL_CTL, UL_VLD, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("unlock2", UL_DAT, UL_CTL, UL_VLD, 1'b0);
        i_rx_block_lock = 1'b1;
        drive(32'h0000001E, 2'b10, 1'b1);
        exp_out("relock.lo", 32'h07070707, 4'hF, 1'b0, 1'b0);
        drive(32'h00000000, 2'b00, 1'b1);
        exp_out("relock.h0", 32'h07070707, 4'hF, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("relock.h1", 32'h07070707, 4'hF, 1'b1, 1'b0);

        // Lock drop while a decoded block is draining
        drive(32'h44332278, 2'b10, 1'b1);
        drive(32'h77665544, 2'b00, 1'b1);
        exp_out("drain.h0", 32'h443322FB, 4'b0001, 1'b1, 1'b0);
        i_rx_block_lock = 1'b0;
        drive(32'h0000001E, 2'b10, 1'b1);
        exp_out("drain.h1", 32'h77665544, 4'b0000, 1'b1, 1'b0);
        drive(32'h00000000, 2'b00, 1'b1);
        exp_out("drain.after", UL_DAT, UL_CTL, UL_VLD, 1'b0);
        i_rx_block_lock = 1'b1;

        // Asynchronous reset in the middle of a block
        drive(32'h44332278, 2'b10, 1'b1);
        drive(32'h77665544, 2'b00, 1'b1);
        exp_out("rst.h0", 32'h443322FB, 4'b0001, 1'b1, 1'b0);
        i_reset_n = 1'b0;
        #1;
        exp_out("rst.async", 32'h07070707, 4'hF, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        exp_out("rst.hold", 32'h07070707, 4'hF, 1'b0, 1'b0);
        i_reset_n = 1'b1;
        drive(32'h00000033, 2'b10, 1'b1);
        drive(32'h33221100, 2'b00, 1'b1);
        exp_out("post.h0", 32'h07070707, 4'hF, 1'b1, 1'b0);
        drive(32'h0, 2'b00, 1'b0);
        exp_out("post.h1", 32'h332211FB, 4'b0001, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
